// File: rtl/btb_2bit_param_if.sv
// ---------------------------------------------------------------------------
// btb_2bit_param_if : IF-stage lookup, EX-stage update and status signals of the BTB
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface btb_2bit_param_if #(
  parameter int PC_W = 16
);
  logic            stall;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] target_pc;
  logic            hit;
  logic            btb_hit_ID_EX;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;
  logic            init_done;

  modport master (
    output pc, stall, upd_en, upd_pc, upd_taken, upd_target,
    input  target_pc, hit, btb_hit_ID_EX, init_done
  );

  modport slave (
    input  pc, stall, upd_en, upd_pc, upd_taken, upd_target,
    output target_pc, hit, btb_hit_ID_EX, init_done
  );
endinterface

`default_nettype wire

// File: rtl/btb_2bit_param.sv
// ---------------------------------------------------------------------------
// btb_2bit_param : direct-mapped BTB with 2-bit saturating direction counters
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btb_2bit_param #(
  parameter int         PC_W      = 16,
  parameter int         IDX_W     = 9,
  parameter logic [1:0] CTR_ALLOC = 2'b10
) (
  input  logic                clk,
  input  logic                rst_n,
  btb_2bit_param_if.slave     bus
);

  localparam int TAG_W = PC_W - IDX_W;
  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] c_PTR_LAST = '1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             init_done_q, init_done_d;
  logic             hit_if_id_q, btb_hit_id_ex_q;

  logic             valid_q [DEPTH];
  logic [TAG_W-1:0] tag_q   [DEPTH];
  logic [1:0]       ctr_q   [DEPTH];
  logic [PC_W-1:0]  tgt_q   [DEPTH];

  logic sweep_en, run_en;

  // ---------------- init FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= init_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == c_PTR_LAST) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end
    end
  end

  always_comb begin
    sweep_en = 1'b0;
    run_en   = 1'b0;
    case (state_q)
      ST_INIT: sweep_en = 1'b1;
      ST_RUN:  run_en   = 1'b1;
      default: ;
    endcase
  end

  // ---------------- lookup ----------------
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             rd_match;

  assign rd_idx   = bus.pc[IDX_W-1:0];
  assign rd_tag   = bus.pc[PC_W-1:IDX_W];
  assign rd_match = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

  assign bus.hit       = init_done_q && rd_match && ctr_q[rd_idx][1];
  assign bus.target_pc = rd_match ? tgt_q[rd_idx] : '0;
  assign bus.init_done = init_done_q;
  assign bus.btb_hit_ID_EX = btb_hit_id_ex_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_if_id_q     <= 1'b0;
      btb_hit_id_ex_q <= 1'b0;
    end else if (!bus.stall) begin
      hit_if_id_q     <= bus.hit;
      btb_hit_id_ex_q <= hit_if_id_q;
    end
  end

  // ---------------- update ----------------
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_match;
  logic [1:0]       up_ctr;
  logic             wr_ctr, wr_alloc, wr_tgt;
  logic [1:0]       ctr_new;

  assign up_idx   = bus.upd_pc[IDX_W-1:0];
  assign up_tag   = bus.upd_pc[PC_W-1:IDX_W];
  assign up_match = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr   = ctr_q[up_idx];

  always_comb begin
    wr_ctr   = 1'b0;
    wr_alloc = 1'b0;
    wr_tgt   = 1'b0;
    ctr_new  = up_ctr;
    if (rst_n && run_en && bus.upd_en) begin
      if (up_match) begin
        wr_ctr = 1'b1;
        if (bus.upd_taken) begin
          if (tgt_q[up_idx] != bus.upd_target) begin
            // A moved target invalidates the confidence built up for the old one
            wr_tgt  = 1'b1;
            ctr_new = CTR_ALLOC;
          end else begin
            ctr_new = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'd1;
          end
        end else begin
          ctr_new = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'd1;
        end
      end else if (bus.upd_taken) begin
        wr_alloc = 1'b1;
        wr_ctr   = 1'b1;
        wr_tgt   = 1'b1;
        ctr_new  = CTR_ALLOC;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && sweep_en) begin
      valid_q[ptr_q] <= 1'b0;
    end else begin
      if (wr_alloc) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
      end
      if (wr_ctr) ctr_q[up_idx] <= ctr_new;
      if (wr_tgt) tgt_q[up_idx] <= bus.upd_target;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_btb_2bit_param.sv
// ---------------------------------------------------------------------------
// tb_btb_2bit_param : directed self-checking bench for btb_2bit_param
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_btb_2bit_param;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  btb_2bit_param_if #(.PC_W(16)) bus ();

  btb_2bit_param #(.PC_W(16), .IDX_W(9), .CTR_ALLOC(2'b10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [15:0] p, input logic tk, input logic [15:0] t);
    bus.upd_en     = 1'b1;
    bus.upd_pc     = p;
    bus.upd_taken  = tk;
    bus.upd_target = t;
    tick();
    bus.upd_en = 1'b0;
  endtask

  // Counts cycles from reset release to init_done; flags any hit seen meanwhile
  task automatic sweep_count(output int n, output logic saw_hit, input logic pulse_upd);
    n = 0;
    saw_hit = 1'b0;
    while (!bus.init_done && n < 600) begin
      if (bus.hit) saw_hit = 1'b1;
      bus.upd_en     = pulse_upd;
      bus.upd_pc     = 16'h0203;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h1234;
      tick();
      n++;
    end
    bus.upd_en = 1'b0;
  endtask

  initial begin
    int   n;
    logic sh;
    rst_n = 1'b0;
    bus.pc = 16'h0203;
    bus.stall = 1'b0;
    bus.upd_en = 1'b0;
    bus.upd_pc = '0;
    bus.upd_taken = 1'b0;
    bus.upd_target = '0;
    repeat (3) tick();
    chk("rst_init_done", {31'b0, bus.init_done}, 0);
    chk("rst_id_ex", {31'b0, bus.btb_hit_ID_EX}, 0);
    chk("rst_hit", {31'b0, bus.hit}, 0);

    rst_n = 1'b1;
    sweep_count(n, sh, 1'b1);
    chk("sweep_cycles", n, 512);
    chk("sweep_hit", {31'b0, sh}, 0);
    chk("post_sweep_hit", {31'b0, bus.hit}, 0);
    chk("post_sweep_tgt", {16'b0, bus.target_pc}, 0);

    // allocate and pipeline
    upd(16'h0203, 1'b1, 16'h1234);
    chk("alloc_hit", {31'b0, bus.hit}, 1);
    chk("alloc_tgt", {16'b0, bus.target_pc}, 32'h1234);
    tick();
    chk("pipe_1", {31'b0, bus.btb_hit_ID_EX}, 0);
    tick();
    chk("pipe_2", {31'b0, bus.btb_hit_ID_EX}, 1);

    // hysteresis
    upd(16'h0203, 1'b0, 16'h1234);
    chk("nt_01_hit", {31'b0, bus.hit}, 0);
    chk("nt_01_tgt", {16'b0, bus.target_pc}, 32'h1234);
    upd(16'h0203, 1'b1, 16'h1234);
    chk("t_10_hit", {31'b0, bus.hit}, 1);
    repeat (3) upd(16'h0203, 1'b1, 16'h1234);
    upd(16'h0203, 1'b0, 16'h1234);
    chk("sat11_nt_hit", {31'b0, bus.hit}, 1);
    upd(16'h0203, 1'b0, 16'h1234);
    chk("nt_01b_hit", {31'b0, bus.hit}, 0);
    repeat (2) upd(16'h0203, 1'b0, 16'h1234);
    chk("c00_valid_tgt", {16'b0, bus.target_pc}, 32'h1234);
    upd(16'h0203, 1'b1, 16'h1234);
    chk("sat00_t_hit", {31'b0, bus.hit}, 0);
    upd(16'h0203, 1'b1, 16'h1234);
    chk("c10_hit", {31'b0, bus.hit}, 1);

    // tag conflict on index 0x003
    upd(16'h0403, 1'b1, 16'h0040);
    chk("conf_old_hit", {31'b0, bus.hit}, 0);
    chk("conf_old_tgt", {16'b0, bus.target_pc}, 0);
    bus.pc = 16'h0403;
    #1;
    chk("conf_new_hit", {31'b0, bus.hit}, 1);
    chk("conf_new_tgt", {16'b0, bus.target_pc}, 32'h0040);

    // target change from ctr=11
    upd(16'h0403, 1'b1, 16'h0040);
    upd(16'h0403, 1'b1, 16'h2000);
    chk("tchg_tgt", {16'b0, bus.target_pc}, 32'h2000);
    upd(16'h0403, 1'b0, 16'h2000);
    chk("tchg_ctr10", {31'b0, bus.hit}, 0);

    // same-index lookup during update: old data before the edge
    bus.upd_en = 1'b1;
    bus.upd_pc = 16'h0403;
    bus.upd_taken = 1'b1;
    bus.upd_target = 16'h3000;
    #1;
    chk("rw_old_tgt", {16'b0, bus.target_pc}, 32'h2000);
    chk("rw_old_hit", {31'b0, bus.hit}, 0);
    tick();
    bus.upd_en = 1'b0;
    chk("rw_new_tgt", {16'b0, bus.target_pc}, 32'h3000);
    chk("rw_new_hit", {31'b0, bus.hit}, 1);

    // stall freezes the hit pipeline
    repeat (2) tick();
    chk("pre_stall", {31'b0, bus.btb_hit_ID_EX}, 1);
    bus.pc = 16'h0203;
    bus.stall = 1'b1;
    repeat (3) tick();
    chk("stall_hold", {31'b0, bus.btb_hit_ID_EX}, 1);
    bus.stall = 1'b0;
    tick();
    chk("unstall_1", {31'b0, bus.btb_hit_ID_EX}, 1);
    tick();
    chk("unstall_2", {31'b0, bus.btb_hit_ID_EX}, 0);

    // reset mid-run, then reset again mid-sweep
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rr_init_done", {31'b0, bus.init_done}, 0);
    chk("rr_id_ex", {31'b0, bus.btb_hit_ID_EX}, 0);
    repeat (100) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sweep_count(n, sh, 1'b0);
    chk("rr_sweep_cycles", n, 512);
    bus.pc = 16'h0403;
    #1;
    chk("rr_miss_hit", {31'b0, bus.hit}, 0);
    chk("rr_miss_tgt", {16'b0, bus.target_pc}, 0);
    bus.pc = 16'h0203;
    #1;
    chk("rr_miss_tgt2", {16'b0, bus.target_pc}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
